// File: rtl/magsq_pkg.sv
// ============================================================================
//  Module  : magsq_pkg
//  Brief   : Shared types and widths for the I/Q mean-power front end
//            that feeds sqrt16i16o.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package magsq_pkg;

    // Sequencer states: capture, square I, square Q, accumulate
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SQI  = 2'd1,
        ST_SQQ  = 2'd2,
        ST_ACC  = 2'd3
    } state_t;

    // A single square never exceeds 2^30, so 31 unsigned bits hold it exactly
    localparam int SQ_W    = 31;
    // I*I + Q*Q never exceeds 2^31
    localparam int SUM_W   = 32;
    // Bit range of the mean that becomes the 16-bit output word
    localparam int RES_MSB = 30;
    localparam int RES_LSB = 15;

endpackage

`default_nettype wire

// File: rtl/sq16.sv
// ============================================================================
//  Module  : sq16
//  Brief   : Registered 16x16 signed squarer, 31-bit unsigned result,
//            one cycle of latency. Time-shared between I and Q.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sq16
    import magsq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] a,
    output logic [SQ_W-1:0]    p
);

    logic [15:0]     mag;
    logic [SQ_W-1:0] p_d;
    logic [SQ_W-1:0] p_q;

    // Squaring the magnitude gives the same result as the signed square;
    // -32768 maps to 16'h8000 which is exactly 32768 unsigned.
    always_comb begin
        mag = a[15] ? 16'(-a) : 16'(a);
        p_d = SQ_W'(mag) * SQ_W'(mag);
    end

    // Product register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) p_q <= '0;
        else     p_q <= p_d;
    end

    assign p = p_q;

endmodule

`default_nettype wire

// File: rtl/magsq_avg16.sv
// ============================================================================
//  Module  : magsq_avg16
//  Brief   : Forms I*I+Q*Q, averages 2**LOG2N samples, scales the mean to
//            an unsigned 16-bit word and paces the result strobes so they
//            never arrive faster than the downstream square rooter accepts.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module magsq_avg16
    import magsq_pkg::*;
#(
    parameter int LOG2N   = 4,
    parameter int MIN_GAP = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] iin,
    input  logic signed [15:0] qin,
    input  logic               iv,
    input  logic               clr_ovr,
    output logic [15:0]        dout,
    output logic               ov,
    output logic               ovr
);

    localparam int ACC_W = SUM_W + LOG2N;
    localparam int CNT_W = LOG2N + 1;
    localparam int GAP_W = (MIN_GAP < 1) ? 1 : $clog2(MIN_GAP + 1);
    localparam int TOP_W = RES_MSB - RES_LSB + 2;   // saturation bit + 16-bit result
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2N) - 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(MIN_GAP);

    state_t             state_q, state_d;
    logic signed [15:0] i_q, i_d, q_q, q_d;
    logic [SQ_W-1:0]    ii_q, ii_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               pend_q, pend_d;
    logic [15:0]        pval_q, pval_d;
    logic [15:0]        dout_q, dout_d;
    logic               ov_q, ov_d;
    logic               ovr_q, ovr_d;

    logic signed [15:0] sq_in;
    logic [SQ_W-1:0]    sq_out;
    logic [SUM_W-1:0]   sum;
    logic [ACC_W-1:0]   total;
    logic [TOP_W-1:0]   mean_top;
    logic [15:0]        result;
    logic               res_valid;
    logic               drop;
    logic               ovr_set;
    logic               gap_rdy;

    // The squarer sees I during SQI and Q otherwise, so Q*Q lands in ACC
    assign sq_in = (state_q == ST_SQI) ? i_q : q_q;

    sq16 u_sq16 (
        .clk (clk),
        .rst (rst),
        .a   (sq_in),
        .p   (sq_out)
    );

    // Sum of squares, running total and the scaled/saturated mean
    always_comb begin
        sum      = SUM_W'(ii_q) + SUM_W'(sq_out);
        total    = acc_q + ACC_W'(sum);
        mean_top = total[LOG2N + RES_LSB +: TOP_W];
        result   = mean_top[TOP_W-1] ? 16'hFFFF : mean_top[15:0];
    end

    // Sequencer, accumulator and sample counter
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        q_d       = q_q;
        ii_d      = ii_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        res_valid = 1'b0;
        drop      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (iv) begin
                    i_d     = iin;
                    q_d     = qin;
                    state_d = ST_SQI;
                end
            end
            ST_SQI: begin
                drop    = iv;
                state_d = ST_SQQ;
            end
            ST_SQQ: begin
                drop    = iv;
                ii_d    = sq_out;       // I*I is ready now; hold it while Q*Q forms
                state_d = ST_ACC;
            end
            ST_ACC: begin
                if (cnt_q == CNT_LAST) begin
                    res_valid = 1'b1;
                    acc_d     = '0;
                    cnt_d     = '0;
                end else begin
                    acc_d     = total;
                    cnt_d     = cnt_q + CNT_W'(1);
                end
                if (iv) begin
                    i_d     = iin;
                    q_d     = qin;
                    state_d = ST_SQI;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output pacing: issue a result only once the gap counter has saturated;
    // otherwise park it, and overwrite a parked one if another arrives.
    always_comb begin
        gap_rdy = (gap_q == GAP_MAX);
        ov_d    = 1'b0;
        dout_d  = dout_q;
        pend_d  = pend_q;
        pval_d  = pval_q;
        ovr_set = 1'b0;
        if (gap_rdy && pend_q) begin
            ov_d   = 1'b1;
            dout_d = pval_q;
            pend_d = res_valid;
            if (res_valid) pval_d = result;
        end else if (gap_rdy && res_valid) begin
            ov_d   = 1'b1;
            dout_d = result;
        end else if (res_valid) begin
            pend_d  = 1'b1;
            pval_d  = result;
            ovr_set = pend_q;
        end

        if (ov_d)         gap_d = '0;
        else if (gap_rdy) gap_d = gap_q;
        else              gap_d = gap_q + GAP_W'(1);

        // A new overrun takes priority over a clear in the same cycle
        if (ovr_set || drop) ovr_d = 1'b1;
        else if (clr_ovr)    ovr_d = 1'b0;
        else                 ovr_d = ovr_q;
    end

    // State registers; the gap counter starts full so the first result is not delayed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            q_q     <= '0;
            ii_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= GAP_MAX;
            pend_q  <= 1'b0;
            pval_q  <= '0;
            dout_q  <= '0;
            ov_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            q_q     <= q_d;
            ii_q    <= ii_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            pend_q  <= pend_d;
            pval_q  <= pval_d;
            dout_q  <= dout_d;
            ov_q    <= ov_d;
            ovr_q   <= ovr_d;
        end
    end

    assign dout = dout_q;
    assign ov   = ov_q;
    assign ovr  = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_magsq_avg16.sv
// ============================================================================
//  Module  : tb_magsq_avg16
//  Brief   : Directed bench for magsq_avg16; one instance with no averaging
//            and one averaging 16 samples share the same stimulus.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_magsq_avg16;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] iin, qin;
    logic               iv, clr_ovr;
    logic [15:0]        dout0, dout4;
    logic               ov0, ov4, ovr0, ovr4;

    int n_tests = 0;
    int n_fail  = 0;

    magsq_avg16 #(.LOG2N(0), .MIN_GAP(18)) dut0 (
        .clk(clk), .rst(rst), .iin(iin), .qin(qin), .iv(iv), .clr_ovr(clr_ovr),
        .dout(dout0), .ov(ov0), .ovr(ovr0)
    );

    magsq_avg16 #(.LOG2N(4), .MIN_GAP(18)) dut4 (
        .clk(clk), .rst(rst), .iin(iin), .qin(qin), .iv(iv), .clr_ovr(clr_ovr),
        .dout(dout4), .ov(ov4), .ovr(ovr4)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Floor square root, standing in for sqrt16i16o on the chained output
    function automatic int isqrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    task automatic apply_reset;
        rst = 1'b1; iv = 1'b0; clr_ovr = 1'b0; iin = '0; qin = '0;
        tick; tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        apply_reset;
        n_tests++; if (dout0 !== 16'h0) begin n_fail++; $display("FAIL reset_dout0 got %h exp 0000", dout0); end
        n_tests++; if (ov0   !== 1'b0)  begin n_fail++; $display("FAIL reset_ov0 got %b exp 0", ov0); end
        n_tests++; if (ovr0  !== 1'b0)  begin n_fail++; $display("FAIL reset_ovr0 got %b exp 0", ovr0); end
        n_tests++; if (dout4 !== 16'h0) begin n_fail++; $display("FAIL reset_dout4 got %h exp 0000", dout4); end
        n_tests++; if (ov4   !== 1'b0)  begin n_fail++; $display("FAIL reset_ov4 got %b exp 0", ov4); end
        n_tests++; if (ovr4  !== 1'b0)  begin n_fail++; $display("FAIL reset_ovr4 got %b exp 0", ovr4); end
    endtask

    // 16384^2 = 2^28 -> bits [30:15] = 0x2000, sqrt = 90
    task automatic test_single;
        iin = 16'sd16384; qin = 16'sd0; iv = 1'b1;
        tick;
        iv = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            n_tests++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL single_early_ov cycle %0d got %b exp 0", j, ov0); end
            tick;
        end
        n_tests++; if (ov0 !== 1'b1) begin n_fail++; $display("FAIL single_ov_latency got %b exp 1", ov0); end
        n_tests++; if (dout0 !== 16'h2000) begin n_fail++; $display("FAIL single_dout got %h exp 2000", dout0); end
        n_tests++; if (isqrt(int'(dout0)) != 90) begin n_fail++; $display("FAIL single_sqrt got %0d exp 90", isqrt(int'(dout0))); end
        tick;
        n_tests++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL single_ov_width got %b exp 0", ov0); end
        n_tests++; if (dout0 !== 16'h2000) begin n_fail++; $display("FAIL single_dout_hold got %h exp 2000", dout0); end
        repeat (20) tick;
    endtask

    // 2 * 2^30 = 2^31 sets mean[31] -> saturate
    task automatic test_saturate;
        iin = -16'sd32768; qin = -16'sd32768; iv = 1'b1;
        tick;
        iv = 1'b0;
        repeat (3) tick;
        n_tests++; if (ov0 !== 1'b1) begin n_fail++; $display("FAIL sat_ov got %b exp 1", ov0); end
        n_tests++; if (dout0 !== 16'hFFFF) begin n_fail++; $display("FAIL sat_dout got %h exp ffff", dout0); end
        n_tests++; if (ovr0 !== 1'b0) begin n_fail++; $display("FAIL sat_ovr got %b exp 0", ovr0); end
        repeat (20) tick;
    endtask

    // 8 x 2^28 over 16 samples -> mean 2^27 -> 0x1000
    task automatic test_average;
        int          nov = 0;
        logic [15:0] last = '0;
        apply_reset;
        for (int s = 0; s < 16; s++) begin
            iin = (s % 2 == 0) ? 16'sd16384 : 16'sd0; qin = 16'sd0; iv = 1'b1;
            tick;
            if (ov4) begin nov++; last = dout4; end
            iv = 1'b0;
            repeat (2) begin
                tick;
                if (ov4) begin nov++; last = dout4; end
            end
        end
        repeat (10) begin
            tick;
            if (ov4) begin nov++; last = dout4; end
        end
        n_tests++; if (nov != 1) begin n_fail++; $display("FAIL avg_ov_count got %0d exp 1", nov); end
        n_tests++; if (last !== 16'h1000) begin n_fail++; $display("FAIL avg_dout got %h exp 1000", last); end
        n_tests++; if (ovr4 !== 1'b0) begin n_fail++; $display("FAIL avg_ovr got %b exp 0", ovr4); end
    endtask

    task automatic test_drop;
        clr_ovr = 1'b1;
        tick;
        clr_ovr = 1'b0;
        n_tests++; if (ovr0 !== 1'b0) begin n_fail++; $display("FAIL drop_pre_clear got %b exp 0", ovr0); end
        iin = 16'sd100; qin = 16'sd100; iv = 1'b1;
        tick;                       // accepted in IDLE
        n_tests++; if (ovr0 !== 1'b0) begin n_fail++; $display("FAIL drop_accept_ovr got %b exp 0", ovr0); end
        tick;                       // second strobe lands in SQI
        iv = 1'b0;
        n_tests++; if (ovr0 !== 1'b1) begin n_fail++; $display("FAIL drop_ovr_set got %b exp 1", ovr0); end
        repeat (3) tick;
        iv = 1'b1;
        tick;                       // accepted
        clr_ovr = 1'b1;
        tick;                       // drop and clear together: set wins
        iv = 1'b0;
        n_tests++; if (ovr0 !== 1'b1) begin n_fail++; $display("FAIL drop_set_wins got %b exp 1", ovr0); end
        tick;                       // clear alone
        clr_ovr = 1'b0;
        n_tests++; if (ovr0 !== 1'b0) begin n_fail++; $display("FAIL drop_clear got %b exp 0", ovr0); end
        repeat (25) tick;
    endtask

    // Sample k carries iin = 256*(k+1) -> result 2*(k+1)^2
    task automatic test_pacing;
        int          t_ov[$];
        logic [15:0] v_ov[$];
        apply_reset;
        for (int cyc = 0; cyc < 70; cyc++) begin
            iv  = (cyc % 3 == 0) && (cyc < 30);
            iin = 16'(256 * (cyc / 3 + 1)); qin = 16'sd0;
            tick;
            if (ov0) begin t_ov.push_back(cyc); v_ov.push_back(dout0); end
        end
        iv = 1'b0;
        n_tests++; if (t_ov.size() != 3) begin n_fail++; $display("FAIL pace_ov_count got %0d exp 3", t_ov.size()); end
        if (t_ov.size() >= 3) begin
            n_tests++; if (v_ov[0] !== 16'd2)   begin n_fail++; $display("FAIL pace_dout0 got %0d exp 2", v_ov[0]); end
            n_tests++; if (v_ov[1] !== 16'd98)  begin n_fail++; $display("FAIL pace_dout1 got %0d exp 98", v_ov[1]); end
            n_tests++; if (v_ov[2] !== 16'd200) begin n_fail++; $display("FAIL pace_dout2 got %0d exp 200", v_ov[2]); end
            n_tests++; if (t_ov[1] - t_ov[0] < 18) begin n_fail++; $display("FAIL pace_gap1 got %0d exp >=18", t_ov[1] - t_ov[0]); end
            n_tests++; if (t_ov[2] - t_ov[1] < 18) begin n_fail++; $display("FAIL pace_gap2 got %0d exp >=18", t_ov[2] - t_ov[1]); end
        end
        n_tests++; if (ovr0 !== 1'b1) begin n_fail++; $display("FAIL pace_ovr got %b exp 1", ovr0); end
    endtask

    task automatic test_reset_mid;
        int nov = 0;
        iin = 16'sd16384; qin = 16'sd0; iv = 1'b1;
        tick;
        iv = 1'b0;
        tick;                       // now in SQQ
        #2 rst = 1'b1;
        #1;
        n_tests++; if (dout0 !== 16'h0) begin n_fail++; $display("FAIL rstmid_dout got %h exp 0000", dout0); end
        n_tests++; if (ovr0 !== 1'b0) begin n_fail++; $display("FAIL rstmid_ovr got %b exp 0", ovr0); end
        n_tests++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL rstmid_ov got %b exp 0", ov0); end
        tick;
        rst = 1'b0;
        repeat (10) begin
            tick;
            if (ov0) nov++;
        end
        n_tests++; if (nov != 0) begin n_fail++; $display("FAIL rstmid_spurious_ov got %0d exp 0", nov); end
        iin = 16'sd0; qin = 16'sd16384; iv = 1'b1;
        tick;
        iv = 1'b0;
        repeat (3) tick;
        n_tests++; if (ov0 !== 1'b1) begin n_fail++; $display("FAIL rstmid_next_ov got %b exp 1", ov0); end
        n_tests++; if (dout0 !== 16'h2000) begin n_fail++; $display("FAIL rstmid_next_dout got %h exp 2000", dout0); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_saturate;
        test_average;
        test_drop;
        test_pacing;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
